axi_wr_arbiter: RTL and testbench

Two-master AXI write-path arbiter placed in front of the single slave write port of the AXI top design. It grants one master's AW burst at a time, routes that master's W beats to the slave until WLAST, returns the slave's B response to the same master, and then rearbitrates. It allows one outstanding write transaction. The read channels are not touched.

---
 rtl/axi_arb_pkg.sv | 35 +++
 rtl/axi_wr_arbiter_if.sv | 45 ++++
 rtl/axi_wr_arbiter_rr_arb2.sv | 23 ++
 rtl/axi_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_axi_wr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types, AXI encodings and payload-width helpers for the two-master AXI write arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} arb_state_t;

    localparam int unsigned FIXED  = 0;
    localparam int unsigned INCR   = 1;
    localparam int unsigned WRAP   = 2;

    localparam int unsigned OKAY   = 0;
    localparam int unsigned EXOKAY = 1;
    localparam int unsigned SLVERR = 2;
    localparam int unsigned DECERR = 3;

    // ID, LEN and STRB all share this width
    function automatic int unsigned id_w(input int unsigned width);
        return width / 8;
    endfunction

    // {id, addr, len, size, burst}
    function automatic int unsigned aw_w(input int unsigned width, input int unsigned size);
        return id_w(width) + width + id_w(width) + size + (size - 1);
    endfunction

    // {id, data, strb, last}
    function automatic int unsigned w_w(input int unsigned width);
        return id_w(width) + width + id_w(width) + 1;
    endfunction

    // {id, resp}
    function automatic int unsigned b_w(input int unsigned width, input int unsigned size);
        return id_w(width) + (size - 1);
    endfunction

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Write-channel bundle between two AXI masters, the arbiter and the single slave port.
// slave modport: arbiter side; master modport: surrounding masters and slave.
interface axi_wr_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 3
);
    localparam int unsigned AWP = axi_arb_pkg::aw_w(WIDTH, SIZE);
    localparam int unsigned WP  = axi_arb_pkg::w_w(WIDTH);
    localparam int unsigned BP  = axi_arb_pkg::b_w(WIDTH, SIZE);

    logic [1:0]       m_awvalid;
    logic [1:0]       m_awready;
    logic [2*AWP-1:0] m_aw;
    logic [1:0]       m_wvalid;
    logic [1:0]       m_wready;
    logic [2*WP-1:0]  m_w;
    logic [1:0]       m_bvalid;
    logic [1:0]       m_bready;
    logic [BP-1:0]    m_b;

    logic             s_awvalid;
    logic             s_awready;
    logic [AWP-1:0]   s_aw;
    logic             s_wvalid;
    logic             s_wready;
    logic [WP-1:0]    s_w;
    logic             s_bvalid;
    logic             s_bready;
    logic [BP-1:0]    s_b;

    modport slave (
        input  m_awvalid, m_aw, m_wvalid, m_w, m_bready,
               s_awready, s_wready, s_bvalid, s_b,
        output m_awready, m_wready, m_bvalid, m_b,
               s_awvalid, s_aw, s_wvalid, s_w, s_bready
    );

    modport master (
        output m_awvalid, m_aw, m_wvalid, m_w, m_bready,
               s_awready, s_wready, s_bvalid, s_b,
        input  m_awready, m_wready, m_bvalid, m_b,
               s_awvalid, s_aw, s_wvalid, s_w, s_bready
    );

endinterface

// File: rtl/axi_wr_arbiter_rr_arb2.sv
// Two-way request picker. Round-robin by default; AXI_WR_ARB_FIXED_PRIO_EN makes master 0 always win.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_c,
    output logic       vld_c
);

    always_comb begin
        vld_c = |req;
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
        gnt_c = ~req[0];
`else
        // on a tie the master not granted last time wins
        if (&req) begin
            gnt_c = ~last;
        end else begin
            gnt_c = req[1];
        end
`endif
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter: one outstanding burst, AW/W/B routed to the granted master.
// AXI_WR_ARB_FIXED_PRIO_EN selects fixed priority (master 0) instead of round-robin.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    axi_wr_arbiter_if.slave        bus,
    output logic                   grant,
    output logic                   busy
);

    localparam int unsigned AWP = aw_w(WIDTH, SIZE);
    localparam int unsigned WP  = w_w(WIDTH);

    arb_state_t     state_q, state_d;
    logic           grant_q, grant_d;
    logic           busy_q,  busy_d;
    logic           last_q;
    logic           arb_gnt_c, arb_vld_c;
    logic [AWP-1:0] aw_sel;
    logic [WP-1:0]  w_sel;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
    assign last_q = 1'b1;
`else
    logic last_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    rr_arb2 u_pick (
        .req   (bus.m_awvalid),
        .last  (last_q),
        .gnt_c (arb_gnt_c),
        .vld_c (arb_vld_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    // Next state plus combinational routing of the granted master's channels
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
        last_d        = last_q;
`endif
        aw_sel        = grant_q ? bus.m_aw[AWP +: AWP] : bus.m_aw[0 +: AWP];
        w_sel         = grant_q ? bus.m_w[WP +: WP]    : bus.m_w[0 +: WP];
        bus.s_awvalid = 1'b0;
        bus.s_aw      = '0;
        bus.s_wvalid  = 1'b0;
        bus.s_w       = '0;
        bus.s_bready  = 1'b0;
        bus.m_awready = '0;
        bus.m_wready  = '0;
        bus.m_bvalid  = '0;
        bus.m_b       = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld_c) begin
                    grant_d = arb_gnt_c;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                bus.s_awvalid          = bus.m_awvalid[grant_q];
                bus.s_aw               = aw_sel;
                bus.m_awready[grant_q] = bus.s_awready;
                if (bus.m_awvalid[grant_q] && bus.s_awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                bus.s_wvalid          = bus.m_wvalid[grant_q];
                bus.s_w               = w_sel;
                bus.m_wready[grant_q] = bus.s_wready;
                // WLAST alone ends the burst; LEN is not counted
                if (bus.m_wvalid[grant_q] && bus.s_wready && w_sel[0]) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.m_bvalid[grant_q] = bus.s_bvalid;
                bus.s_bready          = bus.m_bready[grant_q];
                bus.m_b               = bus.s_b;
                if (bus.s_bvalid && bus.m_bready[grant_q]) begin
                    state_d = IDLE;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
                    last_d  = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: masters push expected AW/W/B payloads, a monitor checks handshakes.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int unsigned AWP = aw_w(32, 3);
    localparam int unsigned WP  = w_w(32);
    localparam int unsigned BP  = b_w(32, 3);

    logic clk = 1'b0;
    logic resetn;
    logic grant, busy;

    always #5 clk = ~clk;

    axi_wr_arbiter_if #(.WIDTH(32), .SIZE(3)) bus_if ();

    axi_wr_arbiter #(.WIDTH(32), .SIZE(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if),
        .grant  (grant),
        .busy   (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_b_cyc = -1;
    bit gap_chk   = 1'b0;
    bit wr_toggle = 1'b0;
    logic [1:0] slv_resp;

    logic [63:0] q_aw0[$], q_aw1[$], q_w0[$], q_w1[$], q_b0[$], q_b1[$];
    int q_g[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every handshake against the scoreboard queues
    initial begin
        logic [63:0] e;
        logic awv_prev;
        logic bi;
        awv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                if (bus_if.s_awvalid && bus_if.s_awready) begin
                    e = 64'hdead;
                    if (q_g.size() > 0) e = 64'(q_g.pop_front());
                    check("aw_grant", 64'(grant), e);
                    e = '1;
                    if (grant) begin
                        if (q_aw1.size() > 0) e = q_aw1.pop_front();
                    end else begin
                        if (q_aw0.size() > 0) e = q_aw0.pop_front();
                    end
                    check("aw_payload", 64'(bus_if.s_aw), e);
                end
                if (gap_chk && last_b_cyc >= 0 && bus_if.s_awvalid && !awv_prev)
                    check("regrant_gap", 64'(cyc - last_b_cyc), 64'd2);
                if (bus_if.s_wvalid && bus_if.s_wready) begin
                    e = '1;
                    if (grant) begin
                        if (q_w1.size() > 0) e = q_w1.pop_front();
                    end else begin
                        if (q_w0.size() > 0) e = q_w0.pop_front();
                    end
                    check("w_beat", 64'(bus_if.s_w), e);
                end
                if (|(bus_if.m_bvalid & bus_if.m_bready)) begin
                    bi = bus_if.m_bvalid[1];
                    check("b_target", 64'(bus_if.m_bvalid), grant ? 64'd2 : 64'd1);
                    e = '1;
                    if (bi) begin
                        if (q_b1.size() > 0) e = q_b1.pop_front();
                    end else begin
                        if (q_b0.size() > 0) e = q_b0.pop_front();
                    end
                    check("b_payload", 64'(bus_if.m_b), e);
                    last_b_cyc = cyc;
                end
            end
            awv_prev = bus_if.s_awvalid;
            cyc++;
        end
    end

    // Slave model: echoes AWID in BID, responds after WLAST, optional W backpressure
    initial begin
        logic [3:0] pend_id;
        logic aw_hs, wl_hs, b_hs;
        pend_id = '0;
        bus_if.s_bvalid = 1'b0;
        bus_if.s_b      = '0;
        forever begin
            @(negedge clk);
            aw_hs = bus_if.s_awvalid && bus_if.s_awready;
            wl_hs = bus_if.s_wvalid && bus_if.s_wready && bus_if.s_w[0];
            b_hs  = bus_if.s_bvalid && bus_if.s_bready;
            if (aw_hs) pend_id = bus_if.s_aw[AWP-1 -: 4];
            @(posedge clk);
            #1;
            if (!resetn) begin
                bus_if.s_bvalid = 1'b0;
            end else begin
                if (b_hs) bus_if.s_bvalid = 1'b0;
                if (wl_hs) begin
                    bus_if.s_bvalid = 1'b1;
                    bus_if.s_b      = {pend_id, slv_resp};
                end
            end
            bus_if.s_wready = wr_toggle ? ~bus_if.s_wready : 1'b1;
        end
    end

    // One master burst; early: W-before-AW cycles, abort: beats before a reset pulse, lat: check AW latency
    task automatic m_write(input int m, input logic [3:0] id, input logic [31:0] addr,
                           input int nbeats, input int bdly, input int early,
                           input int abort, input bit lat);
        logic [AWP-1:0] aw;
        logic [WP-1:0]  w;
        int nexp, to;
        aw   = {id, addr, 4'(nbeats - 1), 3'd2, 2'(INCR)};
        nexp = (abort > 0) ? abort : nbeats;
        if (m == 0) q_aw0.push_back(64'(aw)); else q_aw1.push_back(64'(aw));
        for (int i = 0; i < nexp; i++) begin
            w = {id, addr ^ {id, 28'(i)}, 4'hF, (i == nbeats - 1)};
            if (m == 0) q_w0.push_back(64'(w)); else q_w1.push_back(64'(w));
        end
        if (abort == 0) begin
            if (m == 0) q_b0.push_back(64'({id, slv_resp}));
            else        q_b1.push_back(64'({id, slv_resp}));
        end

        if (early > 0) begin
            bus_if.m_w[m*WP +: WP] = {id, addr, 4'hF, (nbeats == 1)};
            bus_if.m_wvalid[m]     = 1'b1;
            repeat (early) begin
                @(negedge clk);
                check("early_wready", 64'(bus_if.m_wready[m]), 64'd0);
                @(posedge clk);
                #1;
            end
        end

        bus_if.m_aw[m*AWP +: AWP] = aw;
        bus_if.m_awvalid[m]       = 1'b1;
        if (lat) begin
            @(negedge clk);
            check("aw_idle_cycle", 64'(bus_if.s_awvalid), 64'd0);
        end
        to = 0;
        forever begin
            @(negedge clk);
            if (lat && to == 0) check("aw_latency", 64'(bus_if.s_awvalid), 64'd1);
            if (early > 0) check("early_wready_addr", 64'(bus_if.m_wready[m]), 64'd0);
            if (bus_if.m_awready[m]) break;
            if (++to > 300) begin check("aw_timeout", 64'(to), 64'd0); break; end
        end
        @(posedge clk);
        #1;
        bus_if.m_awvalid[m] = 1'b0;

        for (int i = 0; i < nbeats; i++) begin
            if (abort > 0 && i == abort) begin
                bus_if.m_wvalid[m] = 1'b0;
                resetn = 1'b0;
                @(negedge clk);
                check("rst_ctrl", 64'({bus_if.s_awvalid, bus_if.s_wvalid, bus_if.s_bready,
                                       bus_if.m_awready, bus_if.m_wready, bus_if.m_bvalid,
                                       grant, busy}), 64'd0);
                check("rst_payload", 64'(|{bus_if.s_aw, bus_if.s_w, bus_if.m_b}), 64'd0);
                @(posedge clk);
                #1;
                resetn = 1'b1;
                return;
            end
            bus_if.m_w[m*WP +: WP] = {id, addr ^ {id, 28'(i)}, 4'hF, (i == nbeats - 1)};
            bus_if.m_wvalid[m]     = 1'b1;
            to = 0;
            forever begin
                @(negedge clk);
                if (bus_if.m_wready[m]) break;
                if (++to > 300) begin check("w_timeout", 64'(to), 64'd0); break; end
            end
            @(posedge clk);
            #1;
        end
        bus_if.m_wvalid[m] = 1'b0;

        repeat (bdly) begin
            @(negedge clk);
            check("resp_hold_bvalid", 64'(bus_if.m_bvalid[m]), 64'd1);
            check("resp_hold_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        bus_if.m_bready[m] = 1'b1;
        to = 0;
        forever begin
            @(negedge clk);
            if (bus_if.m_bvalid[m]) break;
            if (++to > 300) begin check("b_timeout", 64'(to), 64'd0); break; end
        end
        @(posedge clk);
        #1;
        bus_if.m_bready[m] = 1'b0;
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn           = 1'b0;
        slv_resp         = 2'(OKAY);
        bus_if.m_awvalid = '0;
        bus_if.m_aw      = '0;
        bus_if.m_wvalid  = '0;
        bus_if.m_w       = '0;
        bus_if.m_bready  = '0;
        bus_if.s_awready = 1'b1;
        bus_if.s_wready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({bus_if.s_awvalid, bus_if.s_wvalid, bus_if.s_bready,
                                 bus_if.m_awready, bus_if.m_wready, bus_if.m_bvalid,
                                 grant, busy}), 64'd0);
        check("reset_payload", 64'(|{bus_if.s_aw, bus_if.s_w, bus_if.m_b}), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // single master, 4 beats, BID echoes 0x2
        q_g.push_back(0);
        m_write(0, 4'h2, 32'h100, 4, 0, 0, 0, 1'b1);
        @(negedge clk);
        check("busy_after_b", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // contention straight after reset: 0 then 1
        reset_pulse();
        q_g.push_back(0);
        q_g.push_back(1);
        last_b_cyc = -1;
        gap_chk    = 1'b1;
        fork
            m_write(0, 4'h1, 32'h200, 2, 0, 0, 0, 1'b0);
            m_write(1, 4'h4, 32'h240, 3, 0, 0, 0, 1'b0);
        join
        gap_chk = 1'b0;

        // continuous requests alternate 0,1,0,1
        q_g.push_back(0);
        q_g.push_back(1);
        q_g.push_back(0);
        q_g.push_back(1);
        last_b_cyc = -1;
        gap_chk    = 1'b1;
        fork
            begin
                m_write(0, 4'h3, 32'h300, 2, 0, 0, 0, 1'b0);
                m_write(0, 4'h5, 32'h320, 1, 0, 0, 0, 1'b0);
            end
            begin
                m_write(1, 4'h6, 32'h340, 2, 0, 0, 0, 1'b0);
                m_write(1, 4'h8, 32'h360, 3, 0, 0, 0, 1'b0);
            end
        join
        gap_chk = 1'b0;

        // W backpressure and B held off for 5 cycles
        slv_resp  = 2'(SLVERR);
        wr_toggle = 1'b1;
        q_g.push_back(1);
        m_write(1, 4'h5, 32'h400, 4, 5, 0, 0, 1'b0);
        wr_toggle = 1'b0;
        slv_resp  = 2'(OKAY);

        // W presented two cycles before AW
        q_g.push_back(1);
        m_write(1, 4'h7, 32'h500, 2, 0, 2, 0, 1'b0);

        // leave pointer at 0, abort a burst after 2 beats, then the tie must go to 0
        q_g.push_back(0);
        m_write(0, 4'h9, 32'h600, 1, 0, 0, 0, 1'b0);
        q_g.push_back(0);
        m_write(0, 4'hA, 32'h700, 4, 0, 0, 2, 1'b0);
        q_g.push_back(0);
        q_g.push_back(1);
        fork
            m_write(0, 4'hB, 32'h800, 1, 0, 0, 0, 1'b0);
            m_write(1, 4'hC, 32'h840, 2, 0, 0, 0, 1'b0);
        join

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("left_grants", 64'(q_g.size()), 64'd0);
        check("left_aw", 64'(q_aw0.size() + q_aw1.size()), 64'd0);
        check("left_w", 64'(q_w0.size() + q_w1.size()), 64'd0);
        check("left_b", 64'(q_b0.size() + q_b1.size()), 64'd0);
        check("final_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
